// File: rtl/pulse_transmitter_sequencer_if.sv
// Host-side bus of the pulse transmitter sequencer: symbol memory write port,
// program control and the transmitter pin/status outputs.
interface pulse_transmitter_sequencer_if #(
  parameter int NUM_SYMBOLS     = 8,
  parameter int PRESCALER_WIDTH = 15,
  parameter int TIMER_WIDTH     = 8
);
  localparam int AW = $clog2(NUM_SYMBOLS);
  localparam int PW = $clog2(PRESCALER_WIDTH + 1);
  localparam int SW = 1 + PW + TIMER_WIDTH;

  logic          sym_wr_en;
  logic [AW-1:0] sym_wr_addr;
  logic [SW-1:0] sym_wr_data;
  logic [AW-1:0] sym_last;
  logic [7:0]    loop_count;
  logic          idle_level;
  logic          start;
  logic          stop;
  logic          pin_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] sym_index;

  modport master (
    output sym_wr_en, sym_wr_addr, sym_wr_data, sym_last, loop_count,
           idle_level, start, stop,
    input  pin_out, busy, done, sym_index
  );

  modport slave (
    input  sym_wr_en, sym_wr_addr, sym_wr_data, sym_last, loop_count,
           idle_level, start, stop,
    output pin_out, busy, done, sym_index
  );
endinterface

// File: rtl/pulse_transmitter_sequencer.sv
// Pulse transmitter sequencer: plays a programmed train of {level, prescaler,
// duration} symbols on one pin, timing each symbol with a countdown timer.

// Period timer: while enabled, raises a one-cycle tick after
// (duration << prescaler) + 1 enabled edges; clears whenever disabled.
module pulse_transmitter_countdown_timer #(
  parameter int PRESCALER_WIDTH = 15,
  parameter int TIMER_WIDTH     = 8,
  parameter int PW              = $clog2(PRESCALER_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PW-1:0]          prescaler,
  input  logic [TIMER_WIDTH-1:0] duration,
  output logic                   tick
);
  localparam int CW = TIMER_WIDTH + (1 << PW) - 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CW-1:0] w_limit;

  assign w_limit = CW'(duration) << prescaler;
  assign tick    = r_tick;

  // Count enabled cycles up to the scaled duration, then emit a single tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!en || r_tick) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == w_limit) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end
endmodule

module pulse_transmitter_sequencer #(
  parameter int NUM_SYMBOLS     = 8,
  parameter int PRESCALER_WIDTH = 15,
  parameter int TIMER_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  pulse_transmitter_sequencer_if.slave  bus
);
  localparam int AW = $clog2(NUM_SYMBOLS);
  localparam int PW = $clog2(PRESCALER_WIDTH + 1);
  localparam int SW = 1 + PW + TIMER_WIDTH;
  localparam int TW = PW + TIMER_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [SW-1:0] r_mem [NUM_SYMBOLS];
  logic [1:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_last;
  logic [7:0]    r_loop;
  logic [TW-1:0] r_act;    // {prescaler, duration} of the symbol being played
  logic          r_pin;
  logic          r_busy;
  logic          r_done;

  logic [AW-1:0] w_next_idx;
  logic [SW-1:0] w_mem0;
  logic [SW-1:0] w_memn;
  logic          w_en;
  logic          w_tick;

  assign w_next_idx = r_idx + 1'b1;
  assign w_mem0     = r_mem[0];
  assign w_memn     = r_mem[w_next_idx];
  assign w_en       = (r_state == S_RUN);

  assign bus.pin_out   = r_pin;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sym_index = r_idx;

  pulse_transmitter_countdown_timer #(
    .PRESCALER_WIDTH (PRESCALER_WIDTH),
    .TIMER_WIDTH     (TIMER_WIDTH),
    .PW              (PW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .en        (w_en),
    .prescaler (r_act[TW-1 -: PW]),
    .duration  (r_act[TIMER_WIDTH-1:0]),
    .tick      (w_tick)
  );

  // Symbol memory: host writes land at the next edge; loads read the old word.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_SYMBOLS; i++) r_mem[i] <= '0;
    end else if (bus.sym_wr_en) begin
      r_mem[bus.sym_wr_addr] <= bus.sym_wr_data;
    end
  end

  // Program sequencer: IDLE -> LOAD (timer inputs settle) -> RUN (wait tick).
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_loop  <= '0;
      r_act   <= '0;
      r_pin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop && (r_state != S_IDLE)) begin
        // Abort: back to idle without a done pulse.
        r_state <= S_IDLE;
        r_pin   <= bus.idle_level;
        r_busy  <= 1'b0;
        r_idx   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_pin <= bus.idle_level;
            if (bus.start && !bus.stop) begin
              r_last  <= bus.sym_last;
              r_loop  <= bus.loop_count;
              r_idx   <= '0;
              r_act   <= w_mem0[TW-1:0];
              r_pin   <= w_mem0[SW-1];
              r_busy  <= 1'b1;
              r_state <= S_LOAD;
            end
          end
          S_LOAD: r_state <= S_RUN;
          S_RUN: begin
            if (w_tick) begin
              if (r_idx != r_last) begin
                r_idx   <= w_next_idx;
                r_act   <= w_memn[TW-1:0];
                r_pin   <= w_memn[SW-1];
                r_state <= S_LOAD;
              end else if (r_loop != 8'd0) begin
                r_loop  <= r_loop - 8'd1;
                r_idx   <= '0;
                r_act   <= w_mem0[TW-1:0];
                r_pin   <= w_mem0[SW-1];
                r_state <= S_LOAD;
              end else begin
                r_pin   <= bus.idle_level;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Bench for pulse_transmitter_sequencer: table of programs with hand-computed
// busy/high lengths, a per-cycle reference model for random programs, and
// directed sequences for abort, collisions, write-through and async reset.
module tb_pulse_transmitter_sequencer;
  localparam int NS  = 8;
  localparam int PWD = 15;
  localparam int TWD = 8;
  localparam int AW  = 3;
  localparam int PW  = 4;

  typedef struct {
    int l0, p0, d0;
    int l1, p1, d1;
    int l2, p2, d2;
    int last, loops, idle;
    int exp_busy, exp_high;
  } vec_t;

  typedef struct { int pin; int busy; int idx; } exp_t;

  logic clk = 1'b0;
  logic sys_rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  int   sh_lvl [NS];
  int   sh_pre [NS];
  int   sh_dur [NS];
  exp_t exp_q [$];
  vec_t vecs [7];

  pulse_transmitter_sequencer_if #(.NUM_SYMBOLS(NS), .PRESCALER_WIDTH(PWD), .TIMER_WIDTH(TWD)) bus ();

  pulse_transmitter_sequencer #(.NUM_SYMBOLS(NS), .PRESCALER_WIDTH(PWD), .TIMER_WIDTH(TWD)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, required %0d", nm, $time, act, req);
    end
  endtask

  // idx < 0 means the symbol index is not checked in this cycle.
  task automatic check_cycle(input string nm, input int p, input int b, input int idx, input int d);
    bit ok;
    n_checks++;
    ok = (int'(bus.pin_out) == p) && (int'(bus.busy) == b) && (int'(bus.done) == d) &&
         ((idx < 0) || (int'(bus.sym_index) == idx));
    if (!ok) begin
      n_errors++;
      $display("FAIL %s @%0t: pin/busy/done/idx got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               nm, $time, bus.pin_out, bus.busy, bus.done, bus.sym_index, p, b, d, idx);
    end
  endtask

  // All drive tasks are entered just after a falling edge and return after the next one.
  task automatic wr(input int a, input int l, input int p, input int d);
    bus.sym_wr_en   = 1'b1;
    bus.sym_wr_addr = AW'(a);
    bus.sym_wr_data = {1'(l), PW'(p), TWD'(d)};
    @(negedge clk);
    bus.sym_wr_en   = 1'b0;
    sh_lvl[a] = l; sh_pre[a] = p; sh_dur[a] = d;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Expected per-cycle pin/busy/index: every symbol lasts (dur << pre) + 3 cycles,
  // the whole list repeats loops+1 times.
  task automatic build_model(input int last, input int loops);
    exp_q.delete();
    for (int p = 0; p <= loops; p++)
      for (int i = 0; i <= last; i++) begin
        int len;
        len = (sh_dur[i] << sh_pre[i]) + 3;
        for (int c = 0; c < len; c++) exp_q.push_back('{sh_lvl[i], 1, i});
      end
  endtask

  task automatic play_check(input string nm, input int last, input int loops);
    build_model(last, loops);
    bus.sym_last   = AW'(last);
    bus.loop_count = 8'(loops);
    pulse_start();
    foreach (exp_q[k]) begin
      check_cycle(nm, exp_q[k].pin, 1, exp_q[k].idx, 0);
      @(negedge clk);
    end
    check_cycle({nm, "_done"}, int'(bus.idle_level), 0, -1, 1);
    @(negedge clk);
    check_cycle({nm, "_after"}, int'(bus.idle_level), 0, -1, 0);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int busy_cnt, high, dn;
    wr(0, v.l0, v.p0, v.d0);
    wr(1, v.l1, v.p1, v.d1);
    wr(2, v.l2, v.p2, v.d2);
    bus.idle_level = 1'(v.idle);
    bus.sym_last   = AW'(v.last);
    bus.loop_count = 8'(v.loops);
    @(negedge clk);
    chk($sformatf("vec%0d_idle_pin", k), int'(bus.pin_out), v.idle);
    pulse_start();
    busy_cnt = 0; high = 0; dn = 0;
    while (bus.busy === 1'b1 && busy_cnt < 3000) begin
      busy_cnt++;
      if (bus.pin_out) high++;
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk($sformatf("vec%0d_busy_len", k), busy_cnt, v.exp_busy);
    chk($sformatf("vec%0d_high_len", k), high, v.exp_high);
    chk($sformatf("vec%0d_done_while_busy", k), dn, 0);
    chk($sformatf("vec%0d_done_at_end", k), int'(bus.done), 1);
    chk($sformatf("vec%0d_pin_at_end", k), int'(bus.pin_out), v.idle);
    @(negedge clk);
    chk($sformatf("vec%0d_done_single", k), int'(bus.done), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wlen [4];
    int wlvl [4];
    int widx [4];
    int cyc;

    vecs[0] = '{1,0,5, 0,0,0, 0,0,0, 0,  0, 0,   8,   8};
    vecs[1] = '{1,2,3, 0,0,0, 1,1,4, 2,  0, 0,  29,  26};
    vecs[2] = '{1,2,3, 0,0,0, 1,1,4, 2,  2, 0,  87,  78};
    vecs[3] = '{0,0,0, 0,0,0, 0,0,0, 0,  0, 1,   3,   0};
    vecs[4] = '{1,3,2, 1,0,1, 0,0,0, 1,  1, 0,  46,  46};
    vecs[5] = '{1,0,0, 0,0,0, 0,0,0, 0,255, 0, 768, 768};
    vecs[6] = '{0,1,7, 1,0,2, 0,0,1, 2,  0, 1,  26,   5};

    for (int i = 0; i < NS; i++) begin sh_lvl[i] = 0; sh_pre[i] = 0; sh_dur[i] = 0; end
    sys_rst_n = 1'b0;
    bus.sym_wr_en = 1'b0; bus.sym_wr_addr = '0; bus.sym_wr_data = '0;
    bus.sym_last = '0; bus.loop_count = '0;
    bus.idle_level = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;

    // Reset state, with idle_level high so the reset value of pin_out is visible.
    @(negedge clk);
    @(negedge clk);
    check_cycle("reset_state", 0, 0, 0, 0);
    #2 sys_rst_n = 1'b1;
    @(negedge clk);
    check_cycle("idle_after_reset", 1, 0, 0, 0);

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Prescaled train: widths 15, 3, 11 and index stepping 0, 1, 2.
    bus.idle_level = 1'b0;
    wr(0, 1, 2, 3); wr(1, 0, 0, 0); wr(2, 1, 1, 4);
    play_check("train", 2, 0);
    play_check("train_loop", 2, 2);

    // Abort in the 4th cycle of the 15-cycle first symbol, then replay.
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      check_cycle("abort_pre", 1, 1, 0, 0);
      @(negedge clk);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check_cycle("abort_now", 0, 0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_cycle("abort_quiet", 0, 0, 0, 0);
    end
    play_check("abort_replay", 2, 0);

    // start and stop together from IDLE.
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    check_cycle("start_stop", 0, 0, -1, 0);
    @(negedge clk);
    check_cycle("start_stop_next", 0, 0, -1, 0);

    // stop while idle is ignored; start while busy does not restart.
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check_cycle("stop_idle", 0, 0, -1, 0);
    wr(0, 1, 0, 5);
    bus.sym_last = '0; bus.loop_count = '0;
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      bus.start = (c == 3);
      check_cycle("start_busy", 1, 1, 0, 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_cycle("start_busy_done", 0, 0, -1, 1);
    @(negedge clk);
    check_cycle("start_busy_no_restart", 0, 0, -1, 0);

    // Rewrite mem[0] during symbol 0: 8-cycle width now, 12 on the next loop.
    wr(1, 0, 0, 2);
    bus.sym_last = AW'(1); bus.loop_count = 8'd1;
    wlen = '{8, 5, 12, 5}; wlvl = '{1, 0, 1, 0}; widx = '{0, 1, 0, 1};
    pulse_start();
    cyc = 0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < wlen[s]; c++) begin
        if (cyc == 2) begin
          bus.sym_wr_en = 1'b1; bus.sym_wr_addr = '0;
          bus.sym_wr_data = {1'b1, PW'(0), TWD'(9)};
        end else begin
          bus.sym_wr_en = 1'b0;
        end
        check_cycle("write_through", wlvl[s], 1, widx[s], 0);
        @(negedge clk);
        cyc++;
      end
    sh_lvl[0] = 1; sh_pre[0] = 0; sh_dur[0] = 9;
    check_cycle("write_through_done", 0, 0, -1, 1);
    @(negedge clk);

    // Random programs against the reference model.
    for (int it = 0; it < 10; it++) begin
      for (int a = 0; a < NS; a++)
        wr(a, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 10)));
      bus.idle_level = 1'($urandom_range(0, 1));
      @(negedge clk);
      play_check($sformatf("rand%0d", it), int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset mid-RUN, away from a clock edge.
    bus.idle_level = 1'b0;
    wr(0, 1, 2, 3);
    bus.sym_last = '0; bus.loop_count = '0;
    pulse_start();
    for (int c = 0; c < 5; c++) @(negedge clk);
    check_cycle("pre_async_rst", 1, 1, 0, 0);
    #2 sys_rst_n = 1'b0;
    #1 check_cycle("async_rst", 0, 0, 0, 0);
    bus.idle_level = 1'b1;
    @(negedge clk);
    check_cycle("async_rst_held", 0, 0, 0, 0);
    #2 sys_rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin sh_lvl[i] = 0; sh_pre[i] = 0; sh_dur[i] = 0; end
    @(negedge clk);
    check_cycle("post_rst_idle", 1, 0, 0, 0);
    play_check("post_rst_cleared_mem", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pulse_transmitter_sequencer.md
Name: pulse_transmitter_sequencer

Overview:
- Plays a programmed train of up to NUM_SYMBOLS symbols on a single output pin.
- Each symbol holds an output level and a {prescaler, duration} pair.
- Sequences an internal pulse_transmitter_countdown_timer instance: loads each symbol, enables the timer and advances on the timer's end-of-period pulse.
- Optionally repeats the whole program a set number of times; sits between the host register interface and the transmitter pin.

Parameters:
- NUM_SYMBOLS, 8, symbol memory depth (power of 2, at least 2); AW = clog2(NUM_SYMBOLS).
- PRESCALER_WIDTH, 15, passed to the timer; PW = clog2(PRESCALER_WIDTH+1).
- TIMER_WIDTH, 8, passed to the timer; duration field width.

Ports:
- clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- sym_wr_en  in  1  write strobe for symbol memory.
- sym_wr_addr  in  AW  symbol index to write.
- sym_wr_data  in  1+PW+TIMER_WIDTH  packed as {level, prescaler, duration}, level in the MSB.
- sym_last  in  AW  index of the last symbol in the program; sampled at start.
- loop_count  in  8  extra program repetitions; sampled at start.
- idle_level  in  1  pin level while not busy; used live.
- start  in  1  1-cycle pulse that begins the program.
- stop  in  1  1-cycle pulse that aborts the program.
- pin_out  out  1  transmitter output (registered).
- busy  out  1  high while the program is playing.
- done  out  1  1-cycle pulse on normal completion.
- sym_index  out  AW  index of the active symbol.

Behaviour:
- Reset (async, all registers): pin_out=0, busy=0, done=0, sym_index=0, state IDLE, loop counter=0, active-symbol register=0, symbol memory=0. The internal timer receives sys_rst_n directly.
- Timer interface: prescaler and duration come from the active-symbol register. Timer en = (state==RUN).
- IDLE:
  - pin_out <= idle_level every cycle.
  - On start (and no stop): latch sym_last and loop_count, sym_index<=0, load active-symbol register from mem[0], pin_out<=mem[0].level, busy<=1, go to LOAD.
- LOAD: exactly 1 cycle with en=0, so prescaler/duration are stable 1 cycle before en rises. Then go to RUN.
- RUN:
  - en=1. Wait for the timer pulse, which arrives (duration<<prescaler)+2 cycles after en rises.
  - On the pulse, if sym_index != latched sym_last: sym_index++, load mem[sym_index+1] into the active-symbol register, set pin_out to its level, go to LOAD.
  - Else if the loop counter != 0: decrement it, sym_index<=0, load mem[0], go to LOAD.
  - Else: pin_out<=idle_level, busy<=0, done<=1 for 1 cycle, go to IDLE.
- Symbol period: each symbol holds pin_out for exactly (duration<<prescaler)+3 cycles. The minimum is 3 cycles, at duration=0 and prescaler=0.
- Total length: (loop_count+1) × sum of the symbol periods for indices 0..sym_last.
- Latency: pin_out shows mem[0].level in the first cycle after the edge that samples start.
- stop while busy: at the next edge go to IDLE, pin_out<=idle_level, busy<=0, no done pulse, sym_index<=0. The timer is disabled (en=0).
- start and stop in the same cycle: stop wins; in IDLE nothing happens.
- start while busy: ignored.
- stop while idle: ignored.
- Writes:
  - Writes are accepted at any time and take effect at the next edge.
  - The active symbol was copied to the active-symbol register when loaded, so a write to the active index does not affect the current period. The new value is used the next time that index is loaded.
  - A write and a load of the same index on the same edge: the load uses the old data.
- sym_last and loop_count changes while busy: no effect until the next start.
- The loop counter saturates at 0; loop_count=255 gives 256 passes.

Test Plan:
- Single symbol: mem[0]={1,0,5}, sym_last=0, loop_count=0, idle_level=0, start -> pin_out high for 8 cycles, then low; done pulses exactly once, coincident with the falling edge; busy high for 8 cycles.
- Prescaled train:
  - Program: mem[0]={1,2,3}, mem[1]={0,0,0}, mem[2]={1,1,4}, sym_last=2.
  - Required: pin_out widths 15, 3, 11 cycles; sym_index steps 0,1,2.
- Looping: same program, loop_count=2 -> the 3-symbol pattern repeats 3 times (87 cycles busy); one done pulse.
- Abort: stop in the 4th cycle of a 15-cycle symbol -> pin_out=idle_level and busy=0 next cycle; no done pulse; a following start replays from index 0.
- Collisions and write-through:
  - start+stop in the same cycle from IDLE -> busy stays 0.
  - start during busy -> no restart.
  - Rewriting mem[0] during symbol 0 -> current width unchanged; the new width is used on the next loop.
- Async reset: assert sys_rst_n low mid-RUN, away from a clock edge -> pin_out, busy, done go to 0 immediately; after release the block sits in IDLE driving idle_level.
